// File: rtl/alu_uop_issuer.sv
// alu_uop_issuer
// Decodes 9-bit (3+2*REG_W) instructions into registered ALU micro-ops.
// It issues one micro-op per cycle. SWAP (opcode 111) becomes three XOR
// micro-ops when SWAP_EXPAND_EN is defined. In the default build, SWAP is
// reported as illegal.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds valid and the payload
// stable until that transfer. The uop_* outputs never change while
// uop_valid && !uop_ready.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_instr instruction input {opcode[2:0], a, b}
//   uop_valid/uop_ready        micro-op output handshake
//   uop_alu_op, uop_branch_sel, uop_sub, uop_branch, uop_shift_left
//                              ALU control bundle
//   uop_src1/src2/dst, uop_wr_en, uop_is_branch
//                              register indices and writeback control
//   illegal_op                 one-cycle pulse after an unsupported opcode is accepted
//   state_dbg                  FSM state (0 IDLE, 1 SWAP1, 2 SWAP2)
module alu_uop_issuer #(
  parameter int REG_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [3+2*REG_W-1:0] in_instr,
  output logic               in_ready,
  output logic               uop_valid,
  input  logic               uop_ready,
  output logic [1:0]         uop_alu_op,
  output logic [1:0]         uop_branch_sel,
  output logic               uop_sub,
  output logic               uop_branch,
  output logic               uop_shift_left,
  output logic [REG_W-1:0]   uop_src1,
  output logic [REG_W-1:0]   uop_src2,
  output logic [REG_W-1:0]   uop_dst,
  output logic               uop_wr_en,
  output logic               uop_is_branch,
  output logic               illegal_op,
  output logic [1:0]         state_dbg
);

  localparam int IW = 3 + 2 * REG_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWAP1 = 2'd1;
  localparam logic [1:0] ST_SWAP2 = 2'd2;

  typedef struct packed {
    logic [1:0]       alu_op;
    logic [1:0]       branch_sel;
    logic             sub;
    logic             branch;
    logic             shift_left;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dst;
    logic             wr_en;
    logic             is_branch;
  } uop_t;

  logic [1:0]       state;
  uop_t             uop_q;
  uop_t             dec;
  logic             load_ok;
  logic             accept;
  logic [2:0]       opcode;
  logic [REG_W-1:0] fa;
  logic [REG_W-1:0] fb;

  assign opcode = in_instr[IW-1 -: 3];
  assign fa     = in_instr[2*REG_W-1 -: REG_W];
  assign fb     = in_instr[REG_W-1:0];

  // The output register can take a new op if it is empty or being drained now.
  assign load_ok  = !uop_valid || uop_ready;
  assign in_ready = (state == ST_IDLE) && load_ok;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec            = '0;
    dec.src1       = fa;
    dec.src2       = fb;
    dec.dst        = fa;
    dec.wr_en      = 1'b1;
    case (opcode)
      3'b000: dec.alu_op = 2'b00;
      3'b001: begin
        dec.alu_op = 2'b00;
        dec.sub    = 1'b1;
      end
      3'b010: dec.alu_op = 2'b01;
      3'b011: dec.alu_op = 2'b10;
      3'b100: begin
        dec.alu_op     = 2'b11;
        dec.shift_left = 1'b1;
      end
      3'b101: dec.alu_op = 2'b11;
      3'b110: begin
        // A branch is a subtract that outputs a flag. The flag is picked by b[1:0].
        dec.alu_op     = 2'b00;
        dec.sub        = 1'b1;
        dec.branch     = 1'b1;
        dec.branch_sel = fb[1:0];
        dec.src2       = '0;
        dec.dst        = '0;
        dec.wr_en      = 1'b0;
        dec.is_branch  = 1'b1;
      end
      default: ;  // SWAP handled by the FSM / illegal path
    endcase
  end

`ifdef SWAP_EXPAND_EN
  logic [REG_W-1:0] lat_a;
  logic [REG_W-1:0] lat_b;

  function automatic uop_t xor_op(input logic [REG_W-1:0] d, input logic [REG_W-1:0] s2);
    uop_t u;
    u        = '0;
    u.alu_op = 2'b10;
    u.src1   = d;
    u.src2   = s2;
    u.dst    = d;
    u.wr_en  = 1'b1;
    return u;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      uop_q      <= '0;
      uop_valid  <= 1'b0;
      illegal_op <= 1'b0;
`ifdef SWAP_EXPAND_EN
      lat_a      <= '0;
      lat_b      <= '0;
`endif
    end else begin
      illegal_op <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (opcode == 3'b111) begin
`ifdef SWAP_EXPAND_EN
              // a ^= b, b ^= a, a ^= b, using the a and b captured here.
              lat_a     <= fa;
              lat_b     <= fb;
              uop_q     <= xor_op(fa, fb);
              uop_valid <= 1'b1;
              state     <= ST_SWAP1;
`else
              // Accept implies load_ok, so any held op drains this edge.
              uop_valid  <= 1'b0;
              illegal_op <= 1'b1;
`endif
            end else begin
              uop_q     <= dec;
              uop_valid <= 1'b1;
            end
          end else if (uop_ready) begin
            uop_valid <= 1'b0;
          end
        end
`ifdef SWAP_EXPAND_EN
        ST_SWAP1: begin
          if (uop_ready) begin
            uop_q <= xor_op(lat_b, lat_a);
            state <= ST_SWAP2;
          end
        end
        ST_SWAP2: begin
          if (uop_ready) begin
            uop_q <= xor_op(lat_a, lat_b);
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign uop_alu_op     = uop_q.alu_op;
  assign uop_branch_sel = uop_q.branch_sel;
  assign uop_sub        = uop_q.sub;
  assign uop_branch     = uop_q.branch;
  assign uop_shift_left = uop_q.shift_left;
  assign uop_src1       = uop_q.src1;
  assign uop_src2       = uop_q.src2;
  assign uop_dst        = uop_q.dst;
  assign uop_wr_en      = uop_q.wr_en;
  assign uop_is_branch  = uop_q.is_branch;
  assign state_dbg      = state;

endmodule

// File: tb/tb_alu_uop_issuer.sv
module tb_alu_uop_issuer;

  localparam int W = 18;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;
  logic       uop_valid;
  logic       uop_ready;
  logic [1:0] uop_alu_op;
  logic [1:0] uop_branch_sel;
  logic       uop_sub;
  logic       uop_branch;
  logic       uop_shift_left;
  logic [2:0] uop_src1;
  logic [2:0] uop_src2;
  logic [2:0] uop_dst;
  logic       uop_wr_en;
  logic       uop_is_branch;
  logic       illegal_op;
  logic [1:0] state_dbg;

  alu_uop_issuer #(.REG_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_alu_op(uop_alu_op), .uop_branch_sel(uop_branch_sel), .uop_sub(uop_sub),
    .uop_branch(uop_branch), .uop_shift_left(uop_shift_left),
    .uop_src1(uop_src1), .uop_src2(uop_src2), .uop_dst(uop_dst),
    .uop_wr_en(uop_wr_en), .uop_is_branch(uop_is_branch),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] dut_uop;
  assign dut_uop = {uop_alu_op, uop_branch_sel, uop_sub, uop_branch, uop_shift_left,
                    uop_src1, uop_src2, uop_dst, uop_wr_en, uop_is_branch};

  typedef struct {
    logic [8:0]   instr;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[8];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_uop;
  bit           prev_stall;
  int           total, bad, pushes, pops, waits;

  function automatic logic [W-1:0] pk(input logic [1:0] alu, input logic [1:0] sel,
                                      input logic sub, input logic br, input logic sl,
                                      input logic [2:0] s1, input logic [2:0] s2,
                                      input logic [2:0] d, input logic we, input logic isb);
    return {alu, sel, sub, br, sl, s1, s2, d, we, isb};
  endfunction

  task chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Offer an instruction until it is accepted. Push its expectation when the
  // accepting edge is certain. Return how many cycles in_ready was low.
  task send(input logic [8:0] ins, input logic [W-1:0] e, input bit push, output int w);
    in_valid = 1'b1;
    in_instr = ins;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout instr=%0h", ins);
    end else if (push) begin
      exp_q.push_back(e);
      pushes++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard plus a check that outputs are held during a stall.
  task monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", {uop_valid, 13'd0, dut_uop}, {1'b1, 13'd0, prev_uop});
        if (uop_valid && uop_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_uop actual=%0h required=none", dut_uop);
          end else begin
            e = exp_q.pop_front();
            chk("uop", dut_uop, e);
          end
        end
        prev_stall = uop_valid && !uop_ready;
        prev_uop   = dut_uop;
      end
    end
  endtask

  task drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; pushes = 0; pops = 0; prev_stall = 1'b0; prev_uop = '0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; uop_ready = 1'b0;

    vecs[0] = '{9'b000_001_010, pk(2'b00, 2'b00, 0, 0, 0, 3'd1, 3'd2, 3'd1, 1, 0)};
    vecs[1] = '{9'b001_011_100, pk(2'b00, 2'b00, 1, 0, 0, 3'd3, 3'd4, 3'd3, 1, 0)};
    vecs[2] = '{9'b100_101_110, pk(2'b11, 2'b00, 0, 0, 1, 3'd5, 3'd6, 3'd5, 1, 0)};
    vecs[3] = '{9'b110_011_010, pk(2'b00, 2'b10, 1, 1, 0, 3'd3, 3'd0, 3'd0, 0, 1)};
    vecs[4] = '{9'b010_111_000, pk(2'b01, 2'b00, 0, 0, 0, 3'd7, 3'd0, 3'd7, 1, 0)};
    vecs[5] = '{9'b011_010_001, pk(2'b10, 2'b00, 0, 0, 0, 3'd2, 3'd1, 3'd2, 1, 0)};
    vecs[6] = '{9'b101_100_011, pk(2'b11, 2'b00, 0, 0, 0, 3'd4, 3'd3, 3'd4, 1, 0)};
    vecs[7] = '{9'b110_000_111, pk(2'b00, 2'b11, 1, 1, 0, 3'd0, 3'd0, 3'd0, 0, 1)};

    fork monitor(); join_none

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_uop_valid", uop_valid, 0);
    chk("rst_fields", dut_uop, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", state_dbg, 0);
    @(posedge clk);
    #1;

    // ---------------- table stream, uop_ready high ----------------
    uop_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].instr, vecs[i].exp, 1'b1, waits);
      chk("stream_no_bubble", waits, 0);
    end
    drain();

    // ---------------- backpressure ----------------
    uop_ready = 1'b0;
    send(9'b011_010_001, vecs[5].exp, 1'b1, waits);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", uop_valid, 1);
      chk("bp_uop", dut_uop, vecs[5].exp);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    // Release and accept in the same edge: the new op replaces the old one.
    uop_ready = 1'b1;
    send(9'b000_110_101, pk(2'b00, 2'b00, 0, 0, 0, 3'd6, 3'd5, 3'd6, 1, 0), 1'b1, waits);
    chk("bp_same_cycle_accept", waits, 0);
    drain();

`ifdef SWAP_EXPAND_EN
    // ---------------- SWAP expansion ----------------
    exp_q.push_back(pk(2'b10, 2'b00, 0, 0, 0, 3'd2, 3'd5, 3'd2, 1, 0));
    exp_q.push_back(pk(2'b10, 2'b00, 0, 0, 0, 3'd5, 3'd2, 3'd5, 1, 0));
    exp_q.push_back(pk(2'b10, 2'b00, 0, 0, 0, 3'd2, 3'd5, 3'd2, 1, 0));
    pushes += 3;
    send(9'b111_010_101, '0, 1'b0, waits);
    send(9'b000_001_011, pk(2'b00, 2'b00, 0, 0, 0, 3'd1, 3'd3, 3'd1, 1, 0), 1'b1, waits);
    chk("swap_in_ready_low_cycles", waits, 2);
    drain();

    // ---------------- reset in the middle of a SWAP ----------------
    send(9'b111_011_100, pk(2'b10, 2'b00, 0, 0, 0, 3'd3, 3'd4, 3'd3, 1, 0), 1'b1, waits);
    @(negedge clk);
    #1;
    chk("midswap_first_op_taken", exp_q.size(), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midswap_valid_cleared", uop_valid, 0);
    chk("midswap_in_ready", in_ready, 1);
    chk("midswap_state", state_dbg, 0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
`else
    // ---------------- SWAP without expansion is illegal ----------------
    send(9'b111_001_001, '0, 1'b0, waits);
    @(negedge clk);
    chk("illegal_pulse", illegal_op, 1);
    chk("illegal_no_valid", uop_valid, 0);
    chk("illegal_in_ready", in_ready, 1);
    @(negedge clk);
    chk("illegal_one_cycle", illegal_op, 0);
    chk("illegal_no_valid2", uop_valid, 0);
    @(posedge clk);
    #1;
`endif

    // ---------------- random backpressure stream ----------------
    fork
      begin
        repeat (150) begin
          @(posedge clk);
          #1;
          uop_ready = 1'($urandom_range(0, 1));
        end
        uop_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          int k;
          k = $urandom_range(0, 7);
          send(vecs[k].instr, vecs[k].exp, 1'b1, waits);
        end
      end
    join
    drain();
    chk("push_pop_balance", pops, pushes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
